// File: rtl/debounce_fsm.sv
// debounce_fsm: accepts a sync_in level change after STABLE_CYCLES consecutive enabled samples.
// Define DEBOUNCE_EVENT_CNT_EN to add the 8-bit accepted-rise counter port event_cnt.
module debounce_fsm #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_in,
    input  logic       sample_en,
    output logic       deb_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
`ifdef DEBOUNCE_EVENT_CNT_EN
    output logic [7:0] event_cnt,
`endif
    output logic       busy
);
    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_deb;
    logic                 r_rise;
    logic                 r_fall;
    logic                 w_done;

    // The first sample of a new level is counted on entry to WAIT_*, hence cnt=1 there.
    assign w_done = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (sample_en) begin
                case (r_state)
                    IDLE_LOW: begin
                        r_state <= sync_in ? WAIT_HIGH : IDLE_LOW;
                        r_cnt   <= sync_in ? CNT_WIDTH'(1) : '0;
                    end
                    WAIT_HIGH: begin
                        if (!sync_in) begin
                            r_state <= IDLE_LOW;
                            r_cnt   <= '0;
                        end else if (w_done) begin
                            r_state <= IDLE_HIGH;
                            r_cnt   <= '0;
                            r_deb   <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    IDLE_HIGH: begin
                        r_state <= !sync_in ? WAIT_LOW : IDLE_HIGH;
                        r_cnt   <= !sync_in ? CNT_WIDTH'(1) : '0;
                    end
                    default: begin
                        if (sync_in) begin
                            r_state <= IDLE_HIGH;
                            r_cnt   <= '0;
                        end else if (w_done) begin
                            r_state <= IDLE_LOW;
                            r_cnt   <= '0;
                            r_deb   <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0] r_event_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_event_cnt <= '0;
        else if (sample_en && r_state == WAIT_HIGH && sync_in && w_done)
            r_event_cnt <= r_event_cnt + 1'b1;
    end

    assign event_cnt = r_event_cnt;
`endif

    assign deb_out    = r_deb;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: scoreboard bench for debounce_fsm; expected outputs come from a run-length model.
// Define DEBOUNCE_EVENT_CNT_EN to also check event_cnt including its 255 -> 0 wrap.
module tb_debounce_fsm;
    localparam int SC = 4;

    typedef struct packed {
        logic       deb;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] evt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_in = 1'b0;
    logic       sample_en = 1'b1;
    logic       deb_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] evt_obs;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic       m_deb = 1'b0;
    logic       m_rise = 1'b0;
    logic       m_fall = 1'b0;
    int         m_run = 0;
    logic [7:0] m_evt = '0;

    always #5 clk = ~clk;

    debounce_fsm #(.STABLE_CYCLES(SC), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sample_en  (sample_en),
        .deb_out    (deb_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
`ifdef DEBOUNCE_EVENT_CNT_EN
        .event_cnt  (evt_obs),
`endif
        .busy       (busy)
    );

`ifndef DEBOUNCE_EVENT_CNT_EN
    assign evt_obs = '0;
`endif

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    // A level change is accepted once SC consecutive enabled samples differ from the held level.
    task automatic drive(input logic r, input logic s, input logic en);
        exp_t e;
        rst = r;
        sync_in = s;
        sample_en = en;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            m_deb = 1'b0;
            m_run = 0;
            m_evt = '0;
        end else if (en) begin
            if (s != m_deb) begin
                m_run++;
                if (m_run == SC) begin
                    m_deb = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run = 0;
                    if (s) m_evt = m_evt + 8'd1;
                end
            end else begin
                m_run = 0;
            end
        end
        e.deb = m_deb;
        e.rise = m_rise;
        e.fall = m_fall;
        e.busy = (m_run != 0);
        e.evt = m_evt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("deb_out", 8'(deb_out), 8'(e.deb));
        check("rise_pulse", 8'(rise_pulse), 8'(e.rise));
        check("fall_pulse", 8'(fall_pulse), 8'(e.fall));
        check("busy", 8'(busy), 8'(e.busy));
        check("pulse_excl", 8'(rise_pulse & fall_pulse), 8'd0);
`ifdef DEBOUNCE_EVENT_CNT_EN
        check("event_cnt", evt_obs, e.evt);
`endif
    endtask

    initial begin
        // reset for two edges, release low
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        // clean rise, then one more edge to see the pulse drop
        repeat (5) drive(1'b0, 1'b1, 1'b1);
        // fall with sample_en gaps on every other cycle
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, (i % 2) == 0);
        drive(1'b0, 1'b0, 1'b1);
        // glitch: three high samples then low, rejected
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        // reset while in WAIT_HIGH with cnt=3
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        // random bursts with random qualification
        for (int i = 0; i < 300; i++)
            drive(1'b0, ($urandom_range(0, 9) < 7) ? m_deb ^ (i[4]) : $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
`ifdef DEBOUNCE_EVENT_CNT_EN
        drive(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 257; k++) begin
            repeat (SC) drive(1'b0, 1'b1, 1'b1);
            repeat (SC) drive(1'b0, 1'b0, 1'b1);
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
